rtl_burst_copy_dma: RTL and testbench

RTL_BURST_COPY_DMA -- requirements
Module: rtl_burst_copy_dma

---
 rtl/rtl_burst_copy_dma.sv | 234 +++++++++++++++++++++++
 tb/tb_rtl_burst_copy_dma.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtl_burst_copy_dma.sv
// Burst copy DMA: reads conf_info_size words from offset 0 in CHUNK-sized bursts and writes them back at offset len.
// Optional write-beat counter on the debug port is enabled with the RTL_BURST_COPY_DEBUG_CNT_EN macro.
module rtl_burst_copy_dma #(
    parameter int DMA_W = 32,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      conf_info_size,
    input  logic             conf_done,
    output logic             dma_read_ctrl_valid,
    input  logic             dma_read_ctrl_ready,
    output logic [31:0]      dma_read_ctrl_data_index,
    output logic [31:0]      dma_read_ctrl_data_length,
    output logic [2:0]       dma_read_ctrl_data_size,
    input  logic             dma_read_chnl_valid,
    output logic             dma_read_chnl_ready,
    input  logic [DMA_W-1:0] dma_read_chnl_data,
    output logic             dma_write_ctrl_valid,
    input  logic             dma_write_ctrl_ready,
    output logic [31:0]      dma_write_ctrl_data_index,
    output logic [31:0]      dma_write_ctrl_data_length,
    output logic [2:0]       dma_write_ctrl_data_size,
    output logic             dma_write_chnl_valid,
    input  logic             dma_write_chnl_ready,
    output logic [DMA_W-1:0] dma_write_chnl_data,
    output logic             acc_done,
    output logic [31:0]      debug
);

    localparam int              PTR_W     = $clog2(CHUNK);
    localparam int              CNT_W     = PTR_W + 1;
    localparam logic [31:0]     CHUNK_W   = 32'(CHUNK);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]      BEAT_SIZE = (DMA_W == 64) ? 3'b011 : 3'b010;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RD_REQ  = 4'd1,
        S_RD_DATA = 4'd2,
        S_WR_REQ  = 4'd3,
        S_WR_DATA = 4'd4,
        S_DONE    = 4'd5
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [31:0]       len_r;
    logic [31:0]       len_next_s;
    logic [31:0]       offset_r;
    logic [31:0]       offset_next_s;
    logic [31:0]       offset_adv_s;
    logic [CNT_W-1:0]  rd_cnt_r;
    logic [CNT_W-1:0]  rd_cnt_next_s;
    logic [CNT_W-1:0]  wr_cnt_r;
    logic [CNT_W-1:0]  wr_cnt_next_s;
    logic [31:0]       burst_s;
    logic [31:0]       burst_next_s;
    logic              rd_fire_s;
    logic              wr_fire_s;
    logic              rd_beat_s;
    logic              wr_beat_s;
    logic              rd_last_s;
    logic              wr_last_s;
    logic [DMA_W-1:0]  buf_r [CHUNK];

    // Words left in the transfer, clipped to one buffer's worth.
    function automatic logic [31:0] burst_of(input logic [31:0] len, input logic [31:0] off);
        logic [31:0] remain_s;
        remain_s = len - off;
        if (remain_s > CHUNK_W) begin
            return CHUNK_W;
        end else begin
            return remain_s;
        end
    endfunction

    assign burst_s      = burst_of(len_r, offset_r);
    assign burst_next_s = burst_of(len_next_s, offset_next_s);
    assign offset_adv_s = offset_r + burst_s;
    assign rd_fire_s    = dma_read_ctrl_valid & dma_read_ctrl_ready;
    assign wr_fire_s    = dma_write_ctrl_valid & dma_write_ctrl_ready;
    assign rd_last_s    = (32'(rd_cnt_r) + 32'd1) == burst_s;
    assign wr_last_s    = (32'(wr_cnt_r) + 32'd1) == burst_s;

    // Next-state, length/offset bookkeeping and beat counters.
    always_comb begin
        state_next_s  = state_r;
        len_next_s    = len_r;
        offset_next_s = offset_r;
        rd_cnt_next_s = rd_cnt_r;
        wr_cnt_next_s = wr_cnt_r;
        rd_beat_s     = 1'b0;
        wr_beat_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (conf_done) begin
                    len_next_s    = conf_info_size;
                    offset_next_s = 32'd0;
                    if (conf_info_size != 32'd0) begin
                        state_next_s = S_RD_REQ;
                    end else begin
                        state_next_s = S_DONE;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RD_REQ: begin
                if (rd_fire_s) begin
                    rd_cnt_next_s = CNT_ZERO;
                    state_next_s  = S_RD_DATA;
                end else begin
                    state_next_s  = S_RD_REQ;
                end
            end
            S_RD_DATA: begin
                if (dma_read_chnl_valid && dma_read_chnl_ready) begin
                    rd_beat_s     = 1'b1;
                    rd_cnt_next_s = rd_cnt_r + CNT_ONE;
                    if (rd_last_s) begin
                        state_next_s = S_WR_REQ;
                    end else begin
                        state_next_s = S_RD_DATA;
                    end
                end else begin
                    state_next_s = S_RD_DATA;
                end
            end
            S_WR_REQ: begin
                if (wr_fire_s) begin
                    wr_cnt_next_s = CNT_ZERO;
                    state_next_s  = S_WR_DATA;
                end else begin
                    state_next_s  = S_WR_REQ;
                end
            end
            S_WR_DATA: begin
                if (dma_write_chnl_valid && dma_write_chnl_ready) begin
                    wr_beat_s     = 1'b1;
                    wr_cnt_next_s = wr_cnt_r + CNT_ONE;
                    if (wr_last_s) begin
                        offset_next_s = offset_adv_s;
                        if (offset_adv_s < len_r) begin
                            state_next_s = S_RD_REQ;
                        end else begin
                            state_next_s = S_DONE;
                        end
                    end else begin
                        state_next_s = S_WR_DATA;
                    end
                end else begin
                    state_next_s = S_WR_DATA;
                end
            end
            S_DONE: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State, bookkeeping and all handshake outputs; outputs are loaded from the next state so they track it with no lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r                    <= S_IDLE;
            len_r                      <= 32'd0;
            offset_r                   <= 32'd0;
            rd_cnt_r                   <= CNT_ZERO;
            wr_cnt_r                   <= CNT_ZERO;
            dma_read_ctrl_valid        <= 1'b0;
            dma_read_ctrl_data_index   <= 32'd0;
            dma_read_ctrl_data_length  <= 32'd0;
            dma_read_ctrl_data_size    <= 3'b000;
            dma_read_chnl_ready        <= 1'b0;
            dma_write_ctrl_valid       <= 1'b0;
            dma_write_ctrl_data_index  <= 32'd0;
            dma_write_ctrl_data_length <= 32'd0;
            dma_write_ctrl_data_size   <= 3'b000;
            dma_write_chnl_valid       <= 1'b0;
            dma_write_chnl_data        <= {DMA_W{1'b0}};
            acc_done                   <= 1'b0;
        end else begin
            state_r                    <= state_next_s;
            len_r                      <= len_next_s;
            offset_r                   <= offset_next_s;
            rd_cnt_r                   <= rd_cnt_next_s;
            wr_cnt_r                   <= wr_cnt_next_s;
            dma_read_ctrl_valid        <= (state_next_s == S_RD_REQ);
            dma_read_ctrl_data_index   <= (state_next_s == S_RD_REQ) ? offset_next_s : 32'd0;
            dma_read_ctrl_data_length  <= (state_next_s == S_RD_REQ) ? burst_next_s : 32'd0;
            dma_read_ctrl_data_size    <= (state_next_s == S_RD_REQ) ? BEAT_SIZE : 3'b000;
            dma_read_chnl_ready        <= (state_next_s == S_RD_DATA);
            dma_write_ctrl_valid       <= (state_next_s == S_WR_REQ);
            dma_write_ctrl_data_index  <= (state_next_s == S_WR_REQ) ? (len_next_s + offset_next_s) : 32'd0;
            dma_write_ctrl_data_length <= (state_next_s == S_WR_REQ) ? burst_next_s : 32'd0;
            dma_write_ctrl_data_size   <= (state_next_s == S_WR_REQ) ? BEAT_SIZE : 3'b000;
            dma_write_chnl_valid       <= (state_next_s == S_WR_DATA);
            dma_write_chnl_data        <= (state_next_s == S_WR_DATA) ?
                                          buf_r[wr_cnt_next_s[PTR_W-1:0]] : {DMA_W{1'b0}};
            acc_done                   <= (state_next_s == S_DONE);
        end
    end

    // Chunk buffer; contents are don't-care after reset since the pointers restart.
    always_ff @(posedge clk) begin
        if (!rst && rd_beat_s) begin
            buf_r[rd_cnt_r[PTR_W-1:0]] <= dma_read_chnl_data;
        end
    end

`ifdef RTL_BURST_COPY_DEBUG_CNT_EN
    logic [27:0] dbg_cnt_r;

    // Write beats completed since the last accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_cnt_r <= 28'd0;
        end else if (state_r == S_IDLE && conf_done) begin
            dbg_cnt_r <= 28'd0;
        end else if (wr_beat_s) begin
            dbg_cnt_r <= dbg_cnt_r + 28'd1;
        end
    end

    assign debug = {state_r, dbg_cnt_r};
`else
    assign debug = 32'd0;
`endif

endmodule

// File: tb/tb_rtl_burst_copy_dma.sv
// Self-checking bench for rtl_burst_copy_dma: a randomly stalling DMA responder plus a
// queue-based reference model of the expected burst schedule and copied data.
module tb_rtl_burst_copy_dma;

    localparam int DMA_W = 32;
    localparam int CHUNK = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      conf_info_size = 32'd0;
    logic             conf_done = 1'b0;
    logic             dma_read_ctrl_valid, dma_read_ctrl_ready;
    logic [31:0]      dma_read_ctrl_data_index, dma_read_ctrl_data_length;
    logic [2:0]       dma_read_ctrl_data_size;
    logic             dma_read_chnl_valid, dma_read_chnl_ready;
    logic [DMA_W-1:0] dma_read_chnl_data;
    logic             dma_write_ctrl_valid, dma_write_ctrl_ready;
    logic [31:0]      dma_write_ctrl_data_index, dma_write_ctrl_data_length;
    logic [2:0]       dma_write_ctrl_data_size;
    logic             dma_write_chnl_valid, dma_write_chnl_ready;
    logic [DMA_W-1:0] dma_write_chnl_data;
    logic             acc_done;
    logic [31:0]      debug;

    typedef struct { logic [31:0] index; logic [31:0] length; logic [2:0] size; } req_t;
    typedef struct { logic [31:0] addr; logic [DMA_W-1:0] data; } beat_t;

    req_t        rd_q[$];
    req_t        wr_q[$];
    beat_t       beat_q[$];
    int          done_cnt = 0;
    int          stab_err = 0;
    int          stall_pct = 0;
    logic [31:0] seed = 32'h1234_5678;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    rtl_burst_copy_dma #(.DMA_W(DMA_W), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst),
        .conf_info_size(conf_info_size), .conf_done(conf_done),
        .dma_read_ctrl_valid(dma_read_ctrl_valid), .dma_read_ctrl_ready(dma_read_ctrl_ready),
        .dma_read_ctrl_data_index(dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size(dma_read_ctrl_data_size),
        .dma_read_chnl_valid(dma_read_chnl_valid), .dma_read_chnl_ready(dma_read_chnl_ready),
        .dma_read_chnl_data(dma_read_chnl_data),
        .dma_write_ctrl_valid(dma_write_ctrl_valid), .dma_write_ctrl_ready(dma_write_ctrl_ready),
        .dma_write_ctrl_data_index(dma_write_ctrl_data_index),
        .dma_write_ctrl_data_length(dma_write_ctrl_data_length),
        .dma_write_ctrl_data_size(dma_write_ctrl_data_size),
        .dma_write_chnl_valid(dma_write_chnl_valid), .dma_write_chnl_ready(dma_write_chnl_ready),
        .dma_write_chnl_data(dma_write_chnl_data),
        .acc_done(acc_done), .debug(debug)
    );

    function automatic logic [DMA_W-1:0] src_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic logic go();
        return ($urandom_range(0, 99) >= stall_pct);
    endfunction

    function automatic logic [138:0] all_outs();
        return {dma_read_ctrl_valid, dma_read_chnl_ready, dma_write_ctrl_valid, dma_write_chnl_valid,
                acc_done, dma_read_ctrl_data_size, dma_write_ctrl_data_size,
                dma_read_ctrl_data_index, dma_read_ctrl_data_length,
                dma_write_ctrl_data_index, dma_write_ctrl_data_length};
    endfunction

    // Reference model: expected burst schedule and copied words for a transfer of 'size' words.
    function automatic int copy_errors(input int unsigned size, input int rb, input int wb,
                                       input int db, output string msg);
        int errs = 0;
        int k = 0;
        msg = "none";
        for (longint unsigned off = 0; off < size; off += CHUNK) begin
            logic [31:0] len;
            len = ((size - off) > CHUNK) ? 32'(CHUNK) : 32'(size - off);
            if (rb + k >= rd_q.size() || rd_q[rb+k].index !== 32'(off) ||
                rd_q[rb+k].length !== len || rd_q[rb+k].size !== 3'b010) begin
                if (errs == 0) msg = $sformatf("read request %0d want idx %0d len %0d", k, off, len);
                errs++;
            end
            if (wb + k >= wr_q.size() || wr_q[wb+k].index !== 32'(size + off) ||
                wr_q[wb+k].length !== len || wr_q[wb+k].size !== 3'b010) begin
                if (errs == 0) msg = $sformatf("write request %0d want idx %0d len %0d", k, size + off, len);
                errs++;
            end
            k++;
        end
        if (rd_q.size() - rb != k || wr_q.size() - wb != k) begin
            if (errs == 0) msg = $sformatf("request count rd %0d wr %0d want %0d", rd_q.size() - rb, wr_q.size() - wb, k);
            errs++;
        end
        if (beat_q.size() - db != int'(size)) begin
            if (errs == 0) msg = $sformatf("beat count %0d want %0d", beat_q.size() - db, size);
            errs++;
        end
        for (int i = 0; i < int'(size) && db + i < beat_q.size(); i++) begin
            if (beat_q[db+i].addr !== 32'(size + i) || beat_q[db+i].data !== src_word(32'(i))) begin
                if (errs == 0) msg = $sformatf("beat %0d addr %0h data %0h", i, beat_q[db+i].addr, beat_q[db+i].data);
                errs++;
            end
        end
        return errs;
    endfunction

    // DMA responder: decides ready/valid each negedge and logs every handshake that the next posedge completes.
    initial begin
        int unsigned rd_left = 0;
        logic [31:0] rd_addr = 32'd0;
        logic [31:0] wr_addr = 32'd0;
        bit          w_hold = 1'b0;
        logic [DMA_W-1:0] w_hold_data = '0;
        dma_read_ctrl_ready = 1'b0; dma_read_chnl_valid = 1'b0; dma_read_chnl_data = '0;
        dma_write_ctrl_ready = 1'b0; dma_write_chnl_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (acc_done === 1'b1) done_cnt++;
            if (rst) begin
                rd_left = 0; w_hold = 1'b0;
                dma_read_ctrl_ready = 1'b0; dma_read_chnl_valid = 1'b0;
                dma_write_ctrl_ready = 1'b0; dma_write_chnl_ready = 1'b0;
            end else begin
                if (w_hold && (dma_write_chnl_valid !== 1'b1 || dma_write_chnl_data !== w_hold_data)) stab_err++;
                dma_read_ctrl_ready = go();
                if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
                    rd_q.push_back('{dma_read_ctrl_data_index, dma_read_ctrl_data_length, dma_read_ctrl_data_size});
                    rd_addr = dma_read_ctrl_data_index;
                    rd_left = dma_read_ctrl_data_length;
                end
                dma_write_ctrl_ready = go();
                if (dma_write_ctrl_valid && dma_write_ctrl_ready) begin
                    wr_q.push_back('{dma_write_ctrl_data_index, dma_write_ctrl_data_length, dma_write_ctrl_data_size});
                    wr_addr = dma_write_ctrl_data_index;
                end
                if (rd_left > 0) begin
                    dma_read_chnl_valid = go();
                    dma_read_chnl_data  = src_word(rd_addr);
                end else begin
                    dma_read_chnl_valid = 1'b0;
                end
                if (dma_read_chnl_valid && dma_read_chnl_ready) begin
                    rd_addr++;
                    rd_left--;
                end
                dma_write_chnl_ready = go();
                if (dma_write_chnl_valid && dma_write_chnl_ready) begin
                    beat_q.push_back('{wr_addr, dma_write_chnl_data});
                    wr_addr++;
                    w_hold = 1'b0;
                end else begin
                    w_hold = dma_write_chnl_valid;
                    w_hold_data = dma_write_chnl_data;
                end
            end
        end
    end

    task automatic run_copy(input int unsigned size, input bit inject, output bit timeout);
        int budget = 0;
        int base = done_cnt;
        bit injected = 1'b0;
        @(negedge clk);
        conf_info_size = size;
        conf_done = 1'b1;
        @(negedge clk);
        conf_done = 1'b0;
        conf_info_size = $urandom;
        while (done_cnt == base && budget < 20000) begin
            @(negedge clk);
            budget++;
            if (inject && !injected && dma_read_chnl_ready) begin
                conf_done = 1'b1; conf_info_size = 32'd7; injected = 1'b1;
            end else begin
                conf_done = 1'b0;
            end
        end
        conf_done = 1'b0;
        timeout = (done_cnt == base);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (all_outs() !== 139'd0) begin n_fail++; $display("FAIL reset_during: outputs %h, required 0", all_outs()); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (all_outs() !== 139'd0) begin n_fail++; $display("FAIL reset_after: outputs %h, required 0", all_outs()); end
        n_checks++;
        if (debug !== 32'd0) begin n_fail++; $display("FAIL reset_debug: got %h, required 0", debug); end
    endtask

    task automatic test_zero_size();
        int rb = rd_q.size();
        int wb = wr_q.size();
        int db0 = done_cnt;
        @(negedge clk);
        conf_info_size = 32'd0;
        conf_done = 1'b1;
        @(negedge clk);
        conf_done = 1'b0;
        // Start is sampled at the edge after conf_done rises; the completion pulse follows on that same edge.
        n_checks++;
        if (acc_done !== 1'b1) begin n_fail++; $display("FAIL zero_done_rise: got %b, required 1", acc_done); end
        @(negedge clk);
        n_checks++;
        if (acc_done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width: got %b, required 0", acc_done); end
        repeat (4) @(negedge clk);
        n_checks++;
        if (rd_q.size() != rb || wr_q.size() != wb) begin
            n_fail++; $display("FAIL zero_no_req: rd %0d wr %0d requests, required 0", rd_q.size() - rb, wr_q.size() - wb);
        end
        n_checks++;
        if (done_cnt - db0 != 1) begin n_fail++; $display("FAIL zero_done_count: got %0d, required 1", done_cnt - db0); end
    endtask

    task automatic test_copy(input string name, input int unsigned size, input int stall, input bit inject);
        int rb = rd_q.size();
        int wb = wr_q.size();
        int db = beat_q.size();
        int d0 = done_cnt;
        int s0 = stab_err;
        int errs;
        bit to;
        string msg;
        seed = $urandom;
        stall_pct = stall;
        run_copy(size, inject, to);
        stall_pct = 0;
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: no acc_done, required one", name); end
        errs = copy_errors(size, rb, wb, db, msg);
        n_checks++;
        if (errs !== 0) begin n_fail++; $display("FAIL %s_model: %0d errors (first: %s), required 0", name, errs, msg); end
        n_checks++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL %s_done_count: got %0d, required 1", name, done_cnt - d0); end
        n_checks++;
        if (stab_err - s0 != 0) begin n_fail++; $display("FAIL %s_hold: %0d unstable stalled beats, required 0", name, stab_err - s0); end
    endtask

    task automatic test_conf_ignore();
        test_copy("conf_ignore", 32'd40, 20, 1'b1);
        n_checks++;
`ifdef RTL_BURST_COPY_DEBUG_CNT_EN
        if (debug[27:0] !== 28'd40) begin n_fail++; $display("FAIL debug_count: got %0d, required 40", debug[27:0]); end
`else
        if (debug !== 32'd0) begin n_fail++; $display("FAIL debug_off: got %h, required 0", debug); end
`endif
    endtask

    task automatic test_reset_mid();
        int wb = wr_q.size();
        int budget = 0;
        int d0 = done_cnt;
        seed = $urandom;
        stall_pct = 25;
        @(negedge clk);
        conf_info_size = 32'd40;
        conf_done = 1'b1;
        @(negedge clk);
        conf_done = 1'b0;
        while (!(wr_q.size() - wb >= 2 && dma_write_chnl_valid === 1'b1) && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        n_checks++;
        if (budget >= 5000) begin n_fail++; $display("FAIL reset_mid_reach: chunk 2 write data not reached in %0d cycles", budget); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (all_outs() !== 139'd0) begin n_fail++; $display("FAIL reset_mid_outs: outputs %h, required 0", all_outs()); end
        @(negedge clk);
        rst = 1'b0;
        stall_pct = 0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (done_cnt != d0) begin n_fail++; $display("FAIL reset_mid_no_done: %0d acc_done pulses, required 0", done_cnt - d0); end
        test_copy("after_reset", 32'd3, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            test_copy($sformatf("b2b%0d", i), $urandom_range(1, 70), 30, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_zero_size();
        test_copy("single", 32'd5, 0, 1'b0);
        test_copy("multi", 32'd40, 0, 1'b0);
        test_copy("stalls", 32'd33, 45, 1'b0);
        test_conf_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
